// File: rtl/uart_pkg.sv
// Shared UART definitions: the rx buffer FSM state encoding and common control characters.
package uart_pkg;

    typedef enum logic [1:0] {
        S_PASS,
        S_HOLD,
        S_DRAIN
    } rxbuf_state_t;

    localparam byte CHAR_CR = 8'h0D;
    localparam byte CHAR_LF = 8'h0A;

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte FIFO with first-word-fall-through read: the head byte is always visible on rd_data.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wr_data,
    output logic [7:0]    rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// Buffers bytes from the UART receiver towards the transmitter, with overflow flag and optional line mode.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int         DEPTH    = 16,
    parameter int         AW       = $clog2(DEPTH),
    parameter logic [7:0] EOL_CHAR = CHAR_CR
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          tx_valid,
    output logic [7:0]    tx_data,
    input  logic          tx_ready,
    input  logic          cfg_line_mode,
    input  logic          clr_ovf,
    output logic          ovf,
    output logic [AW:0]   count
);

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          drop;
    logic          eol_in;
    logic          eol_out;
    logic [AW:0]   count_next;
    logic          full_next;
    logic          empty_next;
    logic [AW:0]   pending;
    logic [AW:0]   pending_next;
    logic          forced;
    logic          forced_next;
    rxbuf_state_t  state;
    rxbuf_state_t  state_next;

    // A pop frees a slot in the same cycle, so a byte arriving at full is still accepted then.
    assign pop  = tx_valid && tx_ready;
    assign push = rx_valid && (!full || pop);
    assign drop = rx_valid && full && !pop;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (rx_data),
        .rd_data (tx_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    assign full_next  = (count_next == (AW+1)'(DEPTH));
    assign empty_next = (count_next == '0);

    assign eol_in       = push && (rx_data == EOL_CHAR);
    assign eol_out      = pop && (tx_data == EOL_CHAR);
    assign pending_next = pending + (AW+1)'(eol_in) - (AW+1)'(eol_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            state   <= S_PASS;
            forced  <= 1'b0;
        end else begin
            pending <= pending_next;
            state   <= state_next;
            forced  <= forced_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next  = state;
        forced_next = forced;
        case (state)
            S_PASS: begin
                if (cfg_line_mode && empty) state_next = S_HOLD;
            end
            S_HOLD: begin
                if (!cfg_line_mode) begin
                    state_next = S_PASS;
                end else if (pending_next != '0) begin
                    state_next  = S_DRAIN;
                    forced_next = 1'b0;
                end else if (full_next) begin
                    state_next  = S_DRAIN;
                    forced_next = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!cfg_line_mode) begin
                    state_next  = S_PASS;
                    forced_next = 1'b0;
                end else if (empty_next) begin
                    state_next  = S_HOLD;
                    forced_next = 1'b0;
                end else if (!forced && pending_next == '0) begin
                    state_next = S_HOLD;
                end
            end
            default: begin
                state_next  = S_PASS;
                forced_next = 1'b0;
            end
        endcase
    end

    // Leaving S_DRAIN only follows a pop or an empty buffer, so an offered byte is never withdrawn.
    always_comb begin
        tx_valid = 1'b0;
        case (state)
            S_PASS:  tx_valid = !empty;
            S_DRAIN: tx_valid = !empty;
            default: tx_valid = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: scoreboard of accepted bytes plus directed mode/overflow checks.
module tb_uart_rx_buffer;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst_n;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          cfg_line_mode;
    logic          clr_ovf;
    logic          ovf;
    logic [AW:0]   count;

    int        n_vec = 0;
    int        n_err = 0;
    logic [7:0] exp_q[$];
    int        mdl_cnt;
    bit        mdl_ovf;
    bit        prev_hold;
    logic [7:0] prev_data;
    bit        pop_now;
    bit        push_now;

    uart_rx_buffer #(
        .DEPTH    (DEPTH),
        .EOL_CHAR (8'h0D)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .cfg_line_mode (cfg_line_mode),
        .clr_ovf       (clr_ovf),
        .ovf           (ovf),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Model of occupancy and overflow; popped bytes are compared against the order of accepted pushes.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            mdl_cnt   = 0;
            mdl_ovf   = 1'b0;
            prev_hold = 1'b0;
            prev_data = 8'h00;
        end else begin
            pop_now = tx_valid && tx_ready;
            check("count", count, mdl_cnt);
            check("ovf", ovf, mdl_ovf);
            if (prev_hold) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, prev_data);
            end
            if (pop_now) begin
                if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
                else                   check("tx_data", tx_data, exp_q.pop_front());
            end
            push_now = rx_valid && (mdl_cnt < DEPTH || pop_now);
            if (push_now) exp_q.push_back(rx_data);
            if (rx_valid && !push_now) mdl_ovf = 1'b1;
            else if (clr_ovf)          mdl_ovf = 1'b0;
            mdl_cnt   = mdl_cnt + int'(push_now) - int'(pop_now);
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (count != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", count, 0);
    endtask

    task automatic flush_to_pass();
        cfg_line_mode = 1'b0;
        tx_ready      = 1'b1;
        wait_empty(2 * DEPTH + 8);
        tx_ready = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        rx_valid      = 1'b0;
        rx_data       = 8'h00;
        tx_ready      = 1'b0;
        cfg_line_mode = 1'b0;
        clr_ovf       = 1'b0;
        #12;
        check("rst_count", count, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_ovf", ovf, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Stream burst
        push_byte(8'h41);
        push_byte(8'h42);
        push_byte(8'h43);
        check("burst_count", count, 3);
        check("burst_valid", tx_valid, 1);
        check("burst_head", tx_data, 8'h41);
        tx_ready = 1'b1;
        repeat (3) tick();
        check("burst_empty", count, 0);
        check("burst_valid_low", tx_valid, 0);
        check("burst_sb", exp_q.size(), 0);
        tx_ready = 1'b0;

        // Overflow, clear, and set-wins-over-clear
        for (int i = 0; i <= DEPTH; i++) push_byte(8'(i));
        check("ovf_count", count, DEPTH);
        check("ovf_set", ovf, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_cleared", ovf, 0);
        clr_ovf  = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        tick();
        rx_valid = 1'b0;
        clr_ovf  = 1'b0;
        check("ovf_set_wins", ovf, 1);
        tx_ready = 1'b1;
        wait_empty(DEPTH + 8);
        tx_ready = 1'b0;
        clr_ovf  = 1'b1;
        tick();
        clr_ovf = 1'b0;

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) push_byte(8'h20 + 8'(i));
        tx_ready = 1'b1;
        push_byte(8'h55);
        tx_ready = 1'b0;
        check("full_pp_count", count, DEPTH);
        check("full_pp_ovf", ovf, 0);
        tx_ready = 1'b1;
        wait_empty(DEPTH + 8);
        check("full_pp_sb", exp_q.size(), 0);

        // Line mode: "hi\r"
        cfg_line_mode = 1'b1;
        repeat (2) tick();
        push_byte(8'h68);
        push_byte(8'h69);
        check("line_hold_valid", tx_valid, 0);
        check("line_hold_count", count, 2);
        push_byte(8'h0D);
        check("line_release", tx_valid, 1);
        check("line_head", tx_data, 8'h68);
        repeat (3) tick();
        check("line_done_valid", tx_valid, 0);
        check("line_done_count", count, 0);
        push_byte(8'h78);
        check("line_rehold", tx_valid, 0);
        cfg_line_mode = 1'b0;
        tick();
        check("mode_1to0_valid", tx_valid, 1);
        check("mode_1to0_data", tx_data, 8'h78);
        tick();
        check("mode_1to0_empty", count, 0);

        // Forced drain, then two lines arriving during the drain
        tx_ready      = 1'b0;
        cfg_line_mode = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) push_byte(8'h30 + 8'(i));
        check("forced_valid", tx_valid, 1);
        check("forced_count", count, DEPTH);
        tx_ready = 1'b1;
        push_byte(8'h61);
        push_byte(8'h0D);
        push_byte(8'h62);
        push_byte(8'h0D);
        check("forced_pp_count", count, DEPTH);
        wait_empty(DEPTH + 12);
        check("forced_end_valid", tx_valid, 0);
        push_byte(8'h7A);
        check("forced_end_hold", tx_valid, 0);
        flush_to_pass();

        // Mode 0 -> 1 with data stored keeps draining, then holds
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        cfg_line_mode = 1'b1;
        tick();
        check("mode_0to1_valid", tx_valid, 1);
        tx_ready = 1'b1;
        wait_empty(10);
        push_byte(8'h44);
        tick();
        check("mode_0to1_hold", tx_valid, 0);
        check("mode_0to1_count", count, 1);
        flush_to_pass();

        // Asynchronous reset mid-drain
        for (int i = 0; i <= DEPTH; i++) push_byte(8'hA0 + 8'(i));
        tx_ready = 1'b1;
        repeat (DEPTH - 5) tick();
        tx_ready = 1'b0;
        check("pre_rst_count", count, 5);
        check("pre_rst_valid", tx_valid, 1);
        check("pre_rst_ovf", ovf, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", tx_valid, 0);
        check("async_rst_count", count, 0);
        check("async_rst_ovf", ovf, 0);
        tick();
        rst_n = 1'b1;
        check("post_rst_state", dut.state, S_PASS);
        push_byte(8'h5A);
        check("post_rst_valid", tx_valid, 1);
        check("post_rst_data", tx_data, 8'h5A);
        tx_ready = 1'b1;
        tick();
        check("post_rst_empty", count, 0);
        tx_ready = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
